// File: rtl/sonic_responder_if.sv
// Trig/echo link between a ranging controller (master) and the sensor-side responder (slave).
interface sonic_responder_if;
   logic       trig;
   logic [8:0] distance_cm;
   logic       echo;
   logic       busy;
   logic       trig_err;

   modport master (
      output trig,
      output distance_cm,
      input  echo,
      input  busy,
      input  trig_err
   );

   modport slave (
      input  trig,
      input  distance_cm,
      output echo,
      output busy,
      output trig_err
   );
endinterface

// File: rtl/sonic_responder.sv
// Ultrasonic range-sensor responder: answers a trig pulse with an echo whose width encodes distance_cm.
// Optional macro SONIC_TRIG_CHECK_EN enables the minimum trig width check and the trig_err pulse.
module sonic_responder #(
   parameter int CYCLES_PER_US = 50,
   parameter int US_PER_CM     = 58,
   parameter int MIN_TRIG_US   = 10,
   parameter int ECHO_DELAY_US = 200,
   parameter int MAX_DIST_CM   = 400,
   parameter int TIMEOUT_US    = 38000,
   parameter int HOLDOFF_US    = 1000
) (
   input  logic             clock,
   input  logic             reset,
   sonic_responder_if.slave bus
);

   localparam int               PRE_W    = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYCLES_PER_US - 1);
`ifdef SONIC_TRIG_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_ARM,
      S_IDLE,
      S_TRIG_HI,
      S_DELAY,
      S_ECHO,
      S_HOLDOFF
   } state_t;

   state_t           r_state;
   logic             r_trig_m;
   logic             r_trig_s;
   logic [PRE_W-1:0] r_pre;
   logic [15:0]      r_us;
   logic [8:0]       r_dist_q;
   logic             r_echo;
   logic             r_busy;
   logic             r_trig_err;

   logic             w_tick;
   logic             w_done;
   logic             w_in_range;
   logic             w_trig_long;
   logic             w_trig_ok;
   logic [15:0]      w_us_next;
   logic [15:0]      w_width;
   logic [15:0]      w_target_m1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_trig_m <= 1'b0;
         r_trig_s <= 1'b0;
      end else begin
         r_trig_m <= bus.trig;
         r_trig_s <= r_trig_m;
      end
   end

   assign w_tick     = (r_pre == PRE_LAST);
   assign w_us_next  = (r_us == 16'hFFFF) ? r_us : r_us + 16'd1;
   assign w_in_range = (r_dist_q != 9'd0) && (32'(r_dist_q) <= MAX_DIST_CM);
   assign w_width    = w_in_range ? 16'(32'(r_dist_q) * US_PER_CM) : 16'(TIMEOUT_US);

   // The edge that sees trig_s fall still closes the last high cycle, so it is counted here.
   assign w_trig_long = (r_us >= 16'(MIN_TRIG_US)) ||
                        (w_tick && (r_us == 16'(MIN_TRIG_US - 1)));
   assign w_trig_ok   = !CHECK_EN || w_trig_long;

   always_comb begin
      w_target_m1 = 16'd0;
      case (r_state)
         S_DELAY:   w_target_m1 = 16'(ECHO_DELAY_US - 1);
         S_ECHO:    w_target_m1 = w_width - 16'd1;
         S_HOLDOFF: w_target_m1 = 16'(HOLDOFF_US - 1);
         default:   w_target_m1 = 16'd0;
      endcase
   end

   assign w_done = w_tick && (r_us == w_target_m1);

   // Every state transition clears the prescaler and the us counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= S_ARM;
         r_pre      <= '0;
         r_us       <= 16'd0;
         r_dist_q   <= 9'd0;
         r_echo     <= 1'b0;
         r_busy     <= 1'b0;
         r_trig_err <= 1'b0;
      end else begin
         r_trig_err <= 1'b0;
         if (w_tick) begin
            r_pre <= '0;
            r_us  <= w_us_next;
         end else begin
            r_pre <= r_pre + 1'b1;
         end

         case (r_state)
            S_ARM: begin
               r_pre <= '0;
               r_us  <= 16'd0;
               if (!r_trig_s) r_state <= S_IDLE;
            end
            S_IDLE: begin
               r_pre <= '0;
               r_us  <= 16'd0;
               if (r_trig_s) r_state <= S_TRIG_HI;
            end
            S_TRIG_HI: begin
               if (!r_trig_s) begin
                  r_pre <= '0;
                  r_us  <= 16'd0;
                  if (w_trig_ok) begin
                     r_dist_q <= bus.distance_cm;
                     r_busy   <= 1'b1;
                     r_state  <= S_DELAY;
                  end else begin
                     r_trig_err <= CHECK_EN;
                     r_state    <= S_IDLE;
                  end
               end
            end
            S_DELAY: begin
               if (w_done) begin
                  r_pre   <= '0;
                  r_us    <= 16'd0;
                  r_echo  <= 1'b1;
                  r_state <= S_ECHO;
               end
            end
            S_ECHO: begin
               if (w_done) begin
                  r_pre   <= '0;
                  r_us    <= 16'd0;
                  r_echo  <= 1'b0;
                  r_state <= S_HOLDOFF;
               end
            end
            S_HOLDOFF: begin
               if (w_done) begin
                  r_pre   <= '0;
                  r_us    <= 16'd0;
                  r_busy  <= 1'b0;
                  r_state <= S_ARM;
               end
            end
            default: begin
               r_pre   <= '0;
               r_us    <= 16'd0;
               r_echo  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_ARM;
            end
         endcase
      end
   end

   assign bus.echo     = r_echo;
   assign bus.busy     = r_busy;
   assign bus.trig_err = r_trig_err;

endmodule

// File: tb/tb_sonic_responder.sv
// Directed bench for sonic_responder with scaled-down timing; expected pulses are queued at trigger time
// and checked by a negedge monitor when busy falls.
module tb_sonic_responder;

   localparam int C       = 2;
   localparam int UPC     = 3;
   localparam int MIN_US  = 10;
   localparam int DLY_US  = 20;
   localparam int MAXD    = 400;
   localparam int TMO_US  = 2000;
   localparam int HOLD_US = 50;

   logic clock = 1'b0;
   logic reset = 1'b1;

   sonic_responder_if bus();

   sonic_responder #(
      .CYCLES_PER_US(C),
      .US_PER_CM(UPC),
      .MIN_TRIG_US(MIN_US),
      .ECHO_DELAY_US(DLY_US),
      .MAX_DIST_CM(MAXD),
      .TIMEOUT_US(TMO_US),
      .HOLDOFF_US(HOLD_US)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      int t_fall;
      int rise_dly;
      int width;
      int hold;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int t_fall      = 0;

   int busy_rises  = 0;
   int echo_rises  = 0;
   int err_pulses  = 0;
   int err_hi      = 0;
   int t_busy_rise = 0;
   int t_echo_rise = 0;
   int t_echo_fall = 0;
   int t_err       = 0;
   bit meas_open   = 1'b0;
   bit prev_busy   = 1'b0;
   bit prev_echo   = 1'b0;
   bit prev_err    = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input longint obs, input longint expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic int echo_cycles(input int d);
      if (d >= 1 && d <= MAXD) return d * UPC * C;
      return TMO_US * C;
   endfunction

   task automatic push_meas(input int d);
      exp_t e;
      e.t_fall   = t_fall;
      e.rise_dly = 3 + DLY_US * C;
      e.width    = echo_cycles(d);
      e.hold     = HOLD_US * C;
      exp_q.push_back(e);
   endtask

   task automatic drive_pulse(input int hi, input int d);
      @(posedge clock); #1;
      bus.distance_cm = 9'(d);
      bus.trig        = 1'b1;
      repeat (hi) @(posedge clock);
      #1;
      bus.trig = 1'b0;
      t_fall   = cyc;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clock);
         n++;
      end
      check(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic wait_echo(input string tag, input int budget);
      int n = 0;
      while (bus.echo !== 1'b1 && n < budget) begin
         @(negedge clock);
         n++;
      end
      check(tag, bus.echo, 1);
   endtask

   always @(negedge clock) begin
      if (reset) begin
         meas_open = 1'b0;
         prev_busy = 1'b0;
         prev_echo = 1'b0;
         prev_err  = 1'b0;
      end else begin
         if (bus.busy && !prev_busy) begin
            meas_open   = 1'b1;
            t_busy_rise = cyc;
            echo_rises  = 0;
            busy_rises++;
         end
         if (bus.echo && !prev_echo) begin
            t_echo_rise = cyc;
            echo_rises++;
         end
         if (!bus.echo && prev_echo) t_echo_fall = cyc;
         if (bus.trig_err) err_hi++;
         if (bus.trig_err && !prev_err) begin
            err_pulses++;
            t_err = cyc;
         end
         if (!bus.busy && prev_busy && meas_open) begin
            meas_open = 1'b0;
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $error("FAIL unexpected_meas: observed 1 measurement expected 0");
            end else begin
               mon_e = exp_q.pop_front();
               check("busy_rise", t_busy_rise - mon_e.t_fall, 3);
               check("echo_delay", t_echo_rise - mon_e.t_fall, mon_e.rise_dly);
               check("echo_width", t_echo_fall - t_echo_rise, mon_e.width);
               check("holdoff", cyc - t_echo_fall, mon_e.hold);
               check("echo_count", echo_rises, 1);
            end
         end
         prev_busy = bus.busy;
         prev_echo = bus.echo;
         prev_err  = bus.trig_err;
      end
   end

   initial begin
      int bc;
      int ec;
      int eh;
      bus.trig        = 1'b0;
      bus.distance_cm = 9'd0;
      reset           = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("reset_echo", bus.echo, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_err", bus.trig_err, 0);
      reset = 1'b0;
      repeat (5) @(posedge clock);

      // Nominal measurement at the minimum accepted trig width.
      drive_pulse(MIN_US * C, 10); push_meas(10);
      wait_done("done_d10", 1000);
      drive_pulse(25, 1);          push_meas(1);
      wait_done("done_d1", 1000);

      // Out-of-range distances and the top of the range.
      drive_pulse(25, 0);          push_meas(0);
      wait_done("done_d0", 6000);
      drive_pulse(25, 401);        push_meas(401);
      wait_done("done_d401", 6000);
      drive_pulse(25, 400);        push_meas(400);
      wait_done("done_d400", 4000);

      // Trig one cycle shorter than the minimum.
      bc = busy_rises;
      ec = err_pulses;
      eh = err_hi;
`ifdef SONIC_TRIG_CHECK_EN
      drive_pulse(MIN_US * C - 1, 10);
      repeat (60) @(negedge clock);
      check("short_no_busy", busy_rises, bc);
      check("short_err_pulses", err_pulses - ec, 1);
      check("short_err_width", err_hi - eh, 1);
      check("short_err_time", t_err - t_fall, 3);
`else
      drive_pulse(MIN_US * C - 1, 10); push_meas(10);
      wait_done("done_short", 1000);
      check("short_busy_once", busy_rises - bc, 1);
      check("short_err_quiet", err_hi - eh, 0);
`endif

      // Distance change during DELAY and a second trig during ECHO are ignored.
      drive_pulse(25, 10); push_meas(10);
      repeat (10) @(posedge clock);
      #1 bus.distance_cm = 9'd50;
      wait_echo("echo_up_s5", 200);
      repeat (5) @(posedge clock);
      #1 bus.trig = 1'b1;
      repeat (20) @(posedge clock);
      #1 bus.trig = 1'b0;
      bc = busy_rises;
      wait_done("done_s5", 1000);
      repeat (100) @(negedge clock);
      check("no_second_meas", busy_rises, bc);

      // Trig raised during HOLDOFF and held past its end must not retrigger.
      drive_pulse(25, 10); push_meas(10);
      repeat (3 + DLY_US * C + 60 + 50) @(posedge clock);
      #1 bus.trig = 1'b1;
      wait_done("done_s6", 1000);
      bc = busy_rises;
      repeat (200) @(negedge clock);
      check("held_no_retrig", busy_rises, bc);
      @(posedge clock); #1 bus.trig = 1'b0;
      repeat (30) @(negedge clock);
      check("release_no_retrig", busy_rises, bc);
      drive_pulse(25, 10); push_meas(10);
      wait_done("done_after_hold", 1000);

      // Reset in the middle of ECHO forces echo and busy low at once.
      drive_pulse(25, 400);
      wait_echo("echo_up_s7", 200);
      repeat (100) @(posedge clock);
      #1 reset = 1'b1;
      #1;
      check("rst_mid_echo", bus.echo, 0);
      check("rst_mid_busy", bus.busy, 0);
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      repeat (5) @(posedge clock);
      drive_pulse(25, 10); push_meas(10);
      wait_done("done_after_rst", 1000);

`ifndef SONIC_TRIG_CHECK_EN
      check("err_never", err_pulses, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
